pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Measures an incoming PWM waveform: period and high time in clk_i cycles.
- Converts the pair to a duty code on the same 1/128 scale the team's PWM generator compares against, so 0..127 maps to duty 0..99.2 %, and 128 means constant high.
- Sits on the input side of the chip: it decodes servo pulses (50 Hz) and 960 Hz PWM, and gives loopback self-check of the generator outputs.

Parameters:
- CNT_W, 32, width of the period and high-time counters.
- TIMEOUT, 50000000, clocks without an edge before the input is declared static. Must be < 2^CNT_W-1.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-high reset.
- en_i  input  1  capture enable. Low = synchronous clear to WAIT_RISE.
- pwm_i  input  1  asynchronous PWM input.
- duty_o  output  8  duty code, 0..128.
- high_o  output  CNT_W  last measured high time, in clocks.
- period_o  output  CNT_W  last measured period (rise to rise), in clocks.
- valid_o  output  1  one-cycle pulse when the outputs above are updated.
- busy_o  output  1  high while in DIVIDE.
- timeout_o  output  1  level; the input is static.

Behaviour:

Reset (rst_i high, asynchronous):
- All outputs 0, counters 0, state WAIT_RISE, synchronizer flops 0.

Edge detection:
- pwm_i passes through a 2-FF synchronizer to give pwm_s. pwm_d is pwm_s delayed one cycle.
- rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d.

Counting (per_cnt):
- Loaded with 1 on rise, otherwise increments every cycle.
- Saturates at all-ones.
- On fall, in MEASURE or DIVIDE: hi_cap <= per_cnt.

State machine, states WAIT_RISE, MEASURE, DIVIDE:
- WAIT_RISE:
  - rise -> MEASURE. No result is reported, since no full period exists yet. timeout_o <= 0.
  - fall -> per_cnt <= 1 (restarts the timeout window).
- MEASURE, on rise:
  - per_cap <= per_cnt, hi_lat <= hi_cap.
  - Start the divide; -> DIVIDE.
- DIVIDE:
  - Restoring division of {hi_lat,7'b0} (CNT_W+7 bits) by per_cap.
  - One quotient bit per cycle, exactly 8 cycles, MSB first.
  - After the 8th iteration: duty_o <= quotient, high_o <= hi_lat, period_o <= per_cap, valid_o = 1 for one cycle, -> MEASURE.
  - busy_o is high for all 8 cycles.
- Rise during DIVIDE:
  - per_cnt reloads to 1 and counting continues.
  - The period that ended at that rise is dropped; no second divide is queued.
  - The next rise in MEASURE measures normally.

Arithmetic and latency:
- high < period always, so a measured duty is 0..127. The floor of the quotient is used.
- Latency is fixed at 11 clk_i edges: from the first edge that samples pwm_i = 1 (second rising input edge) to valid_o = 1. That is 2 synchronizer edges, 1 capture edge and 8 divide edges.

Timeout (MEASURE or WAIT_RISE, per_cnt == TIMEOUT, timeout_o == 0):
- timeout_o <= 1.
- duty_o <= pwm_s ? 128 : 0.
- high_o <= 0, period_o <= 0.
- valid_o pulses once; -> WAIT_RISE.
- No further pulses until a rise, or a fall that restarts per_cnt (then a new timeout reports the new level).
- Timeout is not checked during DIVIDE.

en_i low:
- State -> WAIT_RISE, per_cnt/hi_cap <= 0, timeout_o <= 0, valid_o = 0.
- duty_o, high_o and period_o hold.

Reset mid-DIVIDE:
- The result is discarded; no valid_o.

Test Plan:
1. Hold rst_i, toggle pwm_i -> all outputs 0. Release, apply one rise only -> no valid_o, busy_o stays 0.
2. Period 100, high 25 clocks, continuous -> valid_o 11 cycles after each second-and-later rising input edge; period_o=100, high_o=25, duty_o=32.
3. Period 100 high 33 -> duty_o=42. Period 128 high 127 -> duty_o=127. Period 1000 high 1 -> duty_o=0, high_o=1.
4. TIMEOUT=1000. Pulses, then pwm_i held high 3000 cycles -> exactly one valid_o, timeout_o=1, duty_o=128, period_o=0. Drive low -> 1000 cycles later one valid_o, duty_o=0. Resume period 100 high 50 -> timeout_o clears at first rise, duty_o=64 on the following period.
5. Period 6, high 3 -> rises land in DIVIDE alternately; valid_o every 12 cycles, period_o=6, duty_o=64, busy_o 8 cycles each.
6. Assert rst_i 3 cycles into DIVIDE -> no valid_o, outputs 0. Then en_i low for 5 cycles during MEASURE -> outputs hold; after en_i high, first valid only after two further rises.

Source files
------------

// File: rtl/pwm_capture_if.sv
// Bundle of the PWM capture control inputs and measurement outputs.
interface pwm_capture_if #(
  parameter int unsigned CNT_W = 32
);
  logic             en_i;
  logic             pwm_i;
  logic [7:0]       duty_o;
  logic [CNT_W-1:0] high_o;
  logic [CNT_W-1:0] period_o;
  logic             valid_o;
  logic             busy_o;
  logic             timeout_o;

  modport master (
    output en_i, pwm_i,
    input  duty_o, high_o, period_o, valid_o, busy_o, timeout_o
  );

  modport slave (
    input  en_i, pwm_i,
    output duty_o, high_o, period_o, valid_o, busy_o, timeout_o
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time in clk_i cycles and
// converts them to a 1/128 duty code (128 = static high).
module pwm_capture #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 50000000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {WAIT_RISE, MEASURE, DIVIDE} state_e;

  state_e           state_q;
  logic             pwm_m_q, pwm_s_q, pwm_d_q;
  logic             rise, fall;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cap_q, hi_lat_q, per_cap_q;
  logic [CNT_W:0]   rem_q, rem_d, rem_diff;
  logic             rem_ge;
  logic [6:0]       quo_q;
  logic [2:0]       div_cnt_q;
  logic             tmo_hit;
  logic [7:0]       duty_q;
  logic [CNT_W-1:0] high_q, period_q;
  logic             valid_q, busy_q, timeout_q;

  // Synchronize the asynchronous input and keep one delayed copy for edges
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pwm_m_q <= 1'b0;
      pwm_s_q <= 1'b0;
      pwm_d_q <= 1'b0;
    end else begin
      pwm_m_q <= bus.pwm_i;
      pwm_s_q <= pwm_m_q;
      pwm_d_q <= pwm_s_q;
    end
  end

  assign rise = pwm_s_q & ~pwm_d_q;
  assign fall = ~pwm_s_q & pwm_d_q;

  // Period counter: restart on rise (or on fall while idle), else saturating count
  always_comb begin
    per_cnt_d = per_cnt_q;
    if (!bus.en_i) begin
      per_cnt_d = '0;
    end else if (rise || (fall && (state_q == WAIT_RISE))) begin
      per_cnt_d = CNT_W'(1);
    end else if (per_cnt_q != '1) begin
      per_cnt_d = per_cnt_q + CNT_W'(1);
    end
  end

  // One restoring-division step. The remainder is seeded with hi_lat itself
  // instead of shifting dividend bits in; the first step yields quotient bit 7.
  always_comb begin
    rem_diff = rem_q - {1'b0, per_cap_q};
    rem_ge   = (rem_q >= {1'b0, per_cap_q});
    rem_d    = (rem_ge ? rem_diff : rem_q) << 1;
  end

  assign tmo_hit = (state_q != DIVIDE) && (per_cnt_q == CNT_W'(TIMEOUT)) && !timeout_q;

  // Capture FSM with registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= WAIT_RISE;
      per_cnt_q <= '0;
      hi_cap_q  <= '0;
      hi_lat_q  <= '0;
      per_cap_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_cnt_q <= '0;
      duty_q    <= '0;
      high_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      per_cnt_q <= per_cnt_d;
      if (!bus.en_i) begin
        state_q   <= WAIT_RISE;
        hi_cap_q  <= '0;
        timeout_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        if (fall && (state_q != WAIT_RISE)) begin
          hi_cap_q <= per_cnt_q;
        end
        case (state_q)
          WAIT_RISE: begin
            if (rise) begin
              state_q   <= MEASURE;
              timeout_q <= 1'b0;
            end else if (fall) begin
              // counter restarts, so a later timeout reports the new level
              timeout_q <= 1'b0;
            end else if (tmo_hit) begin
              timeout_q <= 1'b1;
              duty_q    <= pwm_s_q ? 8'd128 : 8'd0;
              high_q    <= '0;
              period_q  <= '0;
              valid_q   <= 1'b1;
            end
          end
          MEASURE: begin
            if (rise) begin
              per_cap_q <= per_cnt_q;
              hi_lat_q  <= hi_cap_q;
              rem_q     <= {1'b0, hi_cap_q};
              quo_q     <= '0;
              div_cnt_q <= '0;
              busy_q    <= 1'b1;
              state_q   <= DIVIDE;
            end else if (tmo_hit) begin
              timeout_q <= 1'b1;
              duty_q    <= pwm_s_q ? 8'd128 : 8'd0;
              high_q    <= '0;
              period_q  <= '0;
              valid_q   <= 1'b1;
              state_q   <= WAIT_RISE;
            end
          end
          DIVIDE: begin
            quo_q     <= {quo_q[5:0], rem_ge};
            rem_q     <= rem_d;
            div_cnt_q <= div_cnt_q + 3'd1;
            if (div_cnt_q == 3'd7) begin
              duty_q   <= {quo_q, rem_ge};
              high_q   <= hi_lat_q;
              period_q <= per_cap_q;
              valid_q  <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= MEASURE;
            end
          end
          default: state_q <= WAIT_RISE;
        endcase
      end
    end
  end

  assign bus.duty_o    = duty_q;
  assign bus.high_o    = high_q;
  assign bus.period_o  = period_q;
  assign bus.valid_o   = valid_q;
  assign bus.busy_o    = busy_q;
  assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed, table-driven bench for pwm_capture.
module tb_pwm_capture;

  typedef struct {
    int unsigned per;
    int unsigned hi;
    int unsigned duty;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;
  int unsigned vcnt  = 0;
  int unsigned bcnt  = 0;
  int unsigned vcyc  = 0;
  int unsigned vint  = 0;
  logic [7:0]  l_duty = '0;
  logic [31:0] l_high = '0;
  logic [31:0] l_per  = '0;
  vec_t        vecs[7];

  pwm_capture_if #(.CNT_W(32)) bus ();

  pwm_capture #(.CNT_W(32), .TIMEOUT(1000)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc = cyc + 1;

  // Record every valid pulse and count busy cycles, sampled mid-cycle
  always @(negedge clk_i) begin
    if (bus.valid_o) begin
      vint   = cyc - vcyc;
      vcyc   = cyc;
      vcnt   = vcnt + 1;
      l_duty = bus.duty_o;
      l_high = bus.high_o;
      l_per  = bus.period_o;
    end
    if (bus.busy_o) bcnt = bcnt + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse(input int unsigned p, input int unsigned h);
    bus.pwm_i = 1'b1;
    repeat (h) tick();
    bus.pwm_i = 1'b0;
    repeat (p - h) tick();
  endtask

  task automatic restart();
    bus.en_i = 1'b0;
    repeat (3) tick();
    bus.en_i = 1'b1;
    vcnt = 0;
    bcnt = 0;
    tick();
  endtask

  initial begin
    int unsigned c0;
    int unsigned v0;
    vecs[0] = '{per: 100,  hi: 25,  duty: 32};
    vecs[1] = '{per: 100,  hi: 33,  duty: 42};
    vecs[2] = '{per: 128,  hi: 127, duty: 127};
    vecs[3] = '{per: 1000, hi: 1,   duty: 0};
    vecs[4] = '{per: 100,  hi: 50,  duty: 64};
    vecs[5] = '{per: 200,  hi: 199, duty: 127};
    vecs[6] = '{per: 13,   hi: 1,   duty: 9};

    // Reset held while the input toggles
    bus.en_i  = 1'b1;
    bus.pwm_i = 1'b0;
    rst_i     = 1'b1;
    repeat (6) begin
      bus.pwm_i = ~bus.pwm_i;
      tick();
    end
    chk("rst_duty",    bus.duty_o,    0);
    chk("rst_high",    bus.high_o,    0);
    chk("rst_period",  bus.period_o,  0);
    chk("rst_valid",   bus.valid_o,   0);
    chk("rst_busy",    bus.busy_o,    0);
    chk("rst_timeout", bus.timeout_o, 0);
    bus.pwm_i = 1'b0;
    rst_i     = 1'b0;
    repeat (3) tick();
    vcnt = 0;
    bcnt = 0;
    bus.pwm_i = 1'b1;
    repeat (10) tick();
    bus.pwm_i = 1'b0;
    repeat (50) tick();
    chk("one_rise_valid", vcnt, 0);
    chk("one_rise_busy",  bcnt, 0);

    // Latency from the sampling edge of the second rise, then steady period
    restart();
    pulse(100, 25);
    bus.pwm_i = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 30 && vcnt == 0; i++) tick();
    chk("latency",      vcyc - c0, 11);
    chk("lat_period",   l_per,  100);
    chk("lat_high",     l_high, 25);
    chk("lat_duty",     l_duty, 32);
    chk("lat_busy_len", bcnt,   8);
    while (cyc - c0 < 25) tick();
    bus.pwm_i = 1'b0;
    repeat (75) tick();
    bus.pwm_i = 1'b1;
    repeat (15) tick();
    chk("cont_count",    vcnt, 2);
    chk("cont_interval", vint, 100);
    bus.pwm_i = 1'b0;

    // Table of steady waveforms: three rises give two results
    for (int v = 0; v < 7; v++) begin
      restart();
      pulse(vecs[v].per, vecs[v].hi);
      pulse(vecs[v].per, vecs[v].hi);
      bus.pwm_i = 1'b1;
      repeat (15) tick();
      chk($sformatf("vec%0d_count",  v), vcnt,   2);
      chk($sformatf("vec%0d_duty",   v), l_duty, vecs[v].duty);
      chk($sformatf("vec%0d_high",   v), l_high, vecs[v].hi);
      chk($sformatf("vec%0d_period", v), l_per,  vecs[v].per);
      bus.pwm_i = 1'b0;
      tick();
    end

    // Fast input: every other rise lands in DIVIDE and is dropped
    restart();
    for (int k = 0; k < 40; k++) pulse(6, 3);
    repeat (20) tick();
    chk("fast_count",    vcnt,   20);
    chk("fast_interval", vint,   12);
    chk("fast_period",   l_per,  6);
    chk("fast_high",     l_high, 3);
    chk("fast_duty",     l_duty, 64);
    chk("fast_busy",     bcnt,   160);

    // Reset in the middle of a divide discards the result
    restart();
    pulse(100, 25);
    pulse(100, 25);
    bus.pwm_i = 1'b1;
    for (int i = 0; i < 10 && !bus.busy_o; i++) tick();
    chk("mid_busy_seen", bus.busy_o, 1);
    repeat (3) tick();
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    repeat (5) tick();
    bus.pwm_i = 1'b0;
    repeat (20) tick();
    chk("mid_rst_count",  vcnt,         1);
    chk("mid_rst_duty",   bus.duty_o,   0);
    chk("mid_rst_period", bus.period_o, 0);
    chk("mid_rst_high",   bus.high_o,   0);
    chk("mid_rst_busy",   bus.busy_o,   0);

    // Enable low during MEASURE holds outputs; two rises needed afterwards
    restart();
    pulse(100, 25);
    pulse(100, 25);
    bus.en_i = 1'b0;
    repeat (5) tick();
    chk("en_hold_duty",   bus.duty_o,   32);
    chk("en_hold_high",   bus.high_o,   25);
    chk("en_hold_period", bus.period_o, 100);
    chk("en_hold_count",  vcnt,         1);
    bus.en_i = 1'b1;
    tick();
    pulse(100, 25);
    chk("en_first_rise", vcnt, 1);
    bus.pwm_i = 1'b1;
    repeat (15) tick();
    chk("en_second_rise", vcnt,   2);
    chk("en_second_duty", l_duty, 32);
    bus.pwm_i = 1'b0;
    tick();

    // Timeout on static high, then static low, then recovery
    restart();
    pulse(100, 50);
    pulse(100, 50);
    bus.pwm_i = 1'b1;
    repeat (20) tick();
    vcnt = 0;
    repeat (3000) tick();
    chk("to_hi_count",   vcnt,          1);
    chk("to_hi_flag",    bus.timeout_o, 1);
    chk("to_hi_duty",    bus.duty_o,    128);
    chk("to_hi_period",  bus.period_o,  0);
    chk("to_hi_high",    bus.high_o,    0);
    bus.pwm_i = 1'b0;
    vcnt = 0;
    repeat (900) tick();
    chk("to_lo_early", vcnt, 0);
    repeat (200) tick();
    chk("to_lo_count", vcnt,          1);
    chk("to_lo_duty",  bus.duty_o,    0);
    chk("to_lo_flag",  bus.timeout_o, 1);
    v0 = vcnt;
    pulse(100, 50);
    chk("to_clear_flag",  bus.timeout_o, 0);
    chk("to_clear_count", vcnt,          v0);
    pulse(100, 50);
    chk("to_resume_count",  vcnt,   v0 + 1);
    chk("to_resume_duty",   l_duty, 64);
    chk("to_resume_period", l_per,  100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
